// File: rtl/cam_param_search.sv
// Parametrised CAM: DEPTH x DATA_W entries with valid bits, addressed write, invalidate,
// lowest-free allocate and a one-cycle-latency search returning hit, min/max address and count.

module cam_entry #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              clr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] key,
    output logic              valid,
    output logic              match
);
    logic [DATA_W-1:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (we) begin
            valid <= 1'b1;
            data  <= wdata;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

    // Compares the pre-edge contents, so a same-cycle write is not seen by a search.
    assign match = valid && (data == key);
endmodule

module cam_param_search #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic              alloc_en,
    input  logic [DATA_W-1:0] alloc_data,
    output logic              alloc_ack,
    output logic [ADDR_W-1:0] alloc_addr,
    output logic              cmd_drop,
    input  logic              srch_en,
    input  logic [DATA_W-1:0] srch_key,
    output logic              srch_done,
    output logic              hit,
    output logic [ADDR_W-1:0] min_addr,
    output logic [ADDR_W-1:0] max_addr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  occupancy,
    output logic              full
);
    typedef struct packed {
        logic              hit;
        logic [ADDR_W-1:0] lo;
        logic [ADDR_W-1:0] hi;
        logic [CNT_W-1:0]  cnt;
    } srch_res_t;

    logic [DEPTH-1:0]  valid, match;
    logic [DEPTH-1:0]  wr_sel, inv_sel, free_sel;
    logic [DEPTH-1:0]  ent_we, ent_clr, valid_nxt;
    logic [DATA_W-1:0] ent_wdata;
    logic [ADDR_W-1:0] free_idx;
    logic              any_free, wr_ok, inv_ok;
    logic              wr_do, inv_do, alloc_do, drop_nxt;
    logic [CNT_W-1:0]  occ_nxt;
    srch_res_t         res_nxt, res_q;

    // Address decode doubles as range check: out-of-range addresses select nothing.
    always_comb begin
        wr_sel   = '0;
        inv_sel  = '0;
        free_sel = '0;
        free_idx = '0;
        any_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i]  = (wr_addr == ADDR_W'(i));
            inv_sel[i] = (inv_addr == ADDR_W'(i));
            if (!valid[i] && !any_free) begin
                free_sel[i] = 1'b1;
                free_idx    = ADDR_W'(i);
                any_free    = 1'b1;
            end
        end
    end

    assign wr_ok    = |wr_sel;
    assign inv_ok   = |inv_sel;
    assign wr_do    = wr_en && wr_ok;
    assign inv_do   = !wr_en && inv_en && inv_ok;
    assign alloc_do = !wr_en && !inv_en && alloc_en && any_free;

    always_comb begin
        drop_nxt = 1'b0;
        if (wr_en)
            drop_nxt = !wr_ok || inv_en || alloc_en;
        else if (inv_en)
            drop_nxt = !inv_ok || alloc_en;
        else if (alloc_en)
            drop_nxt = !any_free;
    end

    assign ent_we    = ({DEPTH{wr_do}} & wr_sel) | ({DEPTH{alloc_do}} & free_sel);
    assign ent_clr   = {DEPTH{inv_do}} & inv_sel;
    assign ent_wdata = wr_en ? wr_data : alloc_data;
    assign valid_nxt = (valid & ~ent_clr) | ent_we;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        cam_entry #(.DATA_W(DATA_W)) u_ent (
            .clk   (clk),
            .reset (reset),
            .we    (ent_we[g]),
            .clr   (ent_clr[g]),
            .wdata (ent_wdata),
            .key   (srch_key),
            .valid (valid[g]),
            .match (match[g])
        );
    end

    always_comb begin
        occ_nxt = '0;
        res_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_nxt[i])
                occ_nxt = occ_nxt + CNT_W'(1);
            if (match[i]) begin
                if (!res_nxt.hit)
                    res_nxt.lo = ADDR_W'(i);
                res_nxt.hit = 1'b1;
                res_nxt.hi  = ADDR_W'(i);
                res_nxt.cnt = res_nxt.cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ack  <= 1'b0;
            alloc_addr <= '0;
            cmd_drop   <= 1'b0;
            srch_done  <= 1'b0;
            res_q      <= '0;
            occupancy  <= '0;
            full       <= 1'b0;
        end else begin
            alloc_ack <= alloc_do;
            if (alloc_do)
                alloc_addr <= free_idx;
            cmd_drop  <= drop_nxt;
            srch_done <= srch_en;
            if (srch_en)
                res_q <= res_nxt;
            occupancy <= occ_nxt;
            full      <= (occ_nxt == CNT_W'(DEPTH));
        end
    end

    assign hit       = res_q.hit;
    assign min_addr  = res_q.lo;
    assign max_addr  = res_q.hi;
    assign hit_count = res_q.cnt;
endmodule

// File: tb/tb_cam_param_search.sv
// Randomised + directed bench for cam_param_search against an array/queue reference model.

module tb_cam_param_search;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 0, inv_en = 0, alloc_en = 0, srch_en = 0;
    logic [2:0] wr_addr = 0, inv_addr = 0;
    logic [3:0] wr_data = 0, alloc_data = 0, srch_key = 0;
    logic       alloc_ack, cmd_drop, srch_done, hit, full;
    logic [2:0] alloc_addr, min_addr, max_addr;
    logic [3:0] hit_count, occupancy;

    // second instance for out-of-range addressing
    logic       w6_en = 0, i6_en = 0, z6 = 0;
    logic [2:0] w6_addr = 0, i6_addr = 0;
    logic [3:0] w6_data = 0, z6_data = 0;
    logic       a6_ack, d6_drop, s6_done, h6, f6;
    logic [2:0] a6_addr, mn6, mx6, hc6, occ6;

    int n_chk = 0, n_pass = 0;

    // reference model state and expected outputs
    logic [3:0] m_data [D];
    logic       m_vld  [D];
    logic       e_ack, e_drop, e_done, e_hit, e_full;
    int         e_aaddr, e_min, e_max, e_cnt, e_occ;

    cam_param_search #(.DATA_W(4), .DEPTH(D)) u_dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inv_en(inv_en), .inv_addr(inv_addr),
        .alloc_en(alloc_en), .alloc_data(alloc_data),
        .alloc_ack(alloc_ack), .alloc_addr(alloc_addr), .cmd_drop(cmd_drop),
        .srch_en(srch_en), .srch_key(srch_key), .srch_done(srch_done),
        .hit(hit), .min_addr(min_addr), .max_addr(max_addr), .hit_count(hit_count),
        .occupancy(occupancy), .full(full)
    );

    cam_param_search #(.DATA_W(4), .DEPTH(6)) u_dut6 (
        .clk(clk), .reset(reset),
        .wr_en(w6_en), .wr_addr(w6_addr), .wr_data(w6_data),
        .inv_en(i6_en), .inv_addr(i6_addr),
        .alloc_en(z6), .alloc_data(z6_data),
        .alloc_ack(a6_ack), .alloc_addr(a6_addr), .cmd_drop(d6_drop),
        .srch_en(z6), .srch_key(z6_data), .srch_done(s6_done),
        .hit(h6), .min_addr(mn6), .max_addr(mx6), .hit_count(hc6),
        .occupancy(occ6), .full(f6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Predict outputs from the current inputs and model, clock once, compare everything.
    task automatic tick();
        int q[$];
        int lo;
        if (reset) begin
            for (int i = 0; i < D; i++) begin m_data[i] = 0; m_vld[i] = 0; end
            e_ack = 0; e_drop = 0; e_done = 0; e_hit = 0; e_full = 0;
            e_aaddr = 0; e_min = 0; e_max = 0; e_cnt = 0;
        end else begin
            e_done = srch_en;
            if (srch_en) begin
                for (int i = 0; i < D; i++)
                    if (m_vld[i] && m_data[i] == srch_key) q.push_back(i);
                e_hit = (q.size() > 0);
                e_min = e_hit ? q[0] : 0;
                e_max = e_hit ? q[$] : 0;
                e_cnt = q.size();
            end
            e_ack = 0; e_drop = 0;
            if (wr_en) begin
                m_data[wr_addr] = wr_data; m_vld[wr_addr] = 1;
                e_drop = inv_en || alloc_en;
            end else if (inv_en) begin
                m_vld[inv_addr] = 0;
                e_drop = alloc_en;
            end else if (alloc_en) begin
                lo = -1;
                for (int i = D - 1; i >= 0; i--) if (!m_vld[i]) lo = i;
                if (lo < 0) e_drop = 1;
                else begin
                    m_data[lo] = alloc_data; m_vld[lo] = 1;
                    e_ack = 1; e_aaddr = lo;
                end
            end
        end
        e_occ = 0;
        for (int i = 0; i < D; i++) e_occ += int'(m_vld[i]);
        e_full = (e_occ == D);
        @(posedge clk); #1;
        chk("alloc_ack", alloc_ack, e_ack);
        chk("alloc_addr", alloc_addr, e_aaddr);
        chk("cmd_drop", cmd_drop, e_drop);
        chk("srch_done", srch_done, e_done);
        chk("hit", hit, e_hit);
        chk("min_addr", min_addr, e_min);
        chk("max_addr", max_addr, e_max);
        chk("hit_count", hit_count, e_cnt);
        chk("occupancy", occupancy, e_occ);
        chk("full", full, e_full);
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; inv_en = 0; alloc_en = 0; srch_en = 0;
    endtask

    initial begin
        // reset, then search on an empty CAM
        reset = 1; tick(); idle();
        srch_en = 1; srch_key = 4'h3; tick(); idle();
        chk("dir_empty_done", srch_done, 1);

        // two writes of A, search, invalidate the lower one, search again
        wr_en = 1; wr_addr = 2; wr_data = 4'hA; tick();
        wr_addr = 5; tick(); idle();
        srch_en = 1; srch_key = 4'hA; tick(); idle();
        chk("dir_min2", min_addr, 2); chk("dir_max5", max_addr, 5); chk("dir_cnt2", hit_count, 2);
        inv_en = 1; inv_addr = 2; tick(); idle();
        srch_en = 1; tick(); idle();
        chk("dir_min5", min_addr, 5); chk("dir_cnt1", hit_count, 1);

        // fill by allocation, then one too many
        reset = 1; tick(); idle();
        for (int i = 0; i < 8; i++) begin
            alloc_en = 1; alloc_data = 4'(i); tick();
            chk("dir_alloc_addr", alloc_addr, i);
        end
        chk("dir_full", full, 1);
        tick(); idle();
        chk("dir_alloc9_ack", alloc_ack, 0); chk("dir_alloc9_drop", cmd_drop, 1);

        // read-before-write on a same-cycle write + search
        reset = 1; tick(); idle();
        wr_en = 1; wr_addr = 1; wr_data = 4'h0; tick();
        wr_data = 4'hC; srch_en = 1; srch_key = 4'hC; tick(); idle();
        chk("dir_rbw_miss", hit, 0);
        srch_en = 1; tick(); idle();
        chk("dir_rbw_hit", hit, 1); chk("dir_rbw_min", min_addr, 1);

        // write and invalidate together: write wins, invalidate dropped
        wr_en = 1; inv_en = 1; wr_addr = 3; inv_addr = 1; wr_data = 4'h7; tick(); idle();
        chk("dir_wr_inv_drop", cmd_drop, 1);

        // DEPTH=6: out-of-range write/invalidate are dropped without state change
        w6_en = 1; w6_addr = 7; w6_data = 4'h9;
        @(posedge clk); #1;
        chk("d6_wr7_drop", d6_drop, 1); chk("d6_wr7_occ", occ6, 0);
        w6_addr = 5;
        @(posedge clk); #1;
        chk("d6_wr5_drop", d6_drop, 0); chk("d6_wr5_occ", occ6, 1);
        w6_en = 0; i6_en = 1; i6_addr = 6;
        @(posedge clk); #1;
        chk("d6_inv6_drop", d6_drop, 1); chk("d6_inv6_occ", occ6, 1);
        i6_en = 0;

        // reset the cycle after a search request discards it
        srch_en = 1; srch_key = 4'hC; tick(); idle();
        reset = 1; tick(); idle();
        chk("dir_rst_done", srch_done, 0); chk("dir_rst_occ", occupancy, 0);

        // randomised traffic, narrow key space for frequent hits
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            inv_en     = ($urandom_range(0, 3) == 0);
            alloc_en   = ($urandom_range(0, 2) == 0);
            srch_en    = ($urandom_range(0, 1) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            inv_addr   = 3'($urandom_range(0, 7));
            wr_data    = 4'($urandom_range(0, 3));
            alloc_data = 4'($urandom_range(0, 3));
            srch_key   = 4'($urandom_range(0, 3));
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
